// File: rtl/npu_host_streamer.sv
// npu_host_streamer: replays a host job stream onto the shared npu bus,
// waits out the calculation phase and streams the results back.
// Optional macro NPU_READY_WAIT_EN: CALC also waits for npu_ready, with
// a timeout that finishes the job early and raises err.
module npu_host_streamer #(
    parameter int DW     = 32,
    parameter int WCNT_W = 12,
    parameter int CALC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WCNT_W-1:0] num_w,
    input  logic [CALC_W-1:0] calc_cycles,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_data,
    output logic              s_ready,
    output logic              npu_we,
    output logic              npu_oe,
    inout  wire  [DW-1:0]     npu_data,
    input  logic              npu_ready,
    output logic              res_valid,
    output logic [DW-1:0]     res_data,
    output logic              busy,
`ifdef NPU_READY_WAIT_EN
    output logic              done,
    output logic              err
`else
    output logic              done
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WGT,
        S_INP,
        S_CALC,
        S_READ,
        S_FIN
    } state_t;

    state_t            state_q;
    logic [WCNT_W-1:0] nw_q;
    logic [WCNT_W-1:0] idx_q;
    logic [CALC_W-1:0] calc_q;
    logic [CALC_W-1:0] cyc_q;
    logic [4:0]        nin_q;
    logic [4:0]        nout_q;
    logic              sr_q;
    logic              we_q;
    logic              oe_q;
    logic              rv_q;
    logic              busy_q;
    logic              done_q;
    logic [DW-1:0]     wd_q;
    logic [DW-1:0]     rd_q;
    logic              xfer;

`ifdef NPU_READY_WAIT_EN
    logic [CALC_W-1:0] tmo_q;
    logic              err_q;

    assign err = err_q;
`else
    logic unused_ready;

    assign unused_ready = npu_ready;
`endif

    // s_ready is only ever high in HDR/WGT/INP
    assign xfer      = s_valid & sr_q;

    assign s_ready   = sr_q;
    assign npu_we    = we_q;
    assign npu_oe    = oe_q;
    assign res_valid = rv_q;
    assign res_data  = rd_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Bus is only driven in the cycle after a host word was accepted
    assign npu_data  = we_q ? wd_q : {DW{1'bz}};

    // Job sequencer with registered bus, handshake and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            nw_q    <= '0;
            idx_q   <= '0;
            calc_q  <= '0;
            cyc_q   <= '0;
            nin_q   <= '0;
            nout_q  <= '0;
            sr_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
`ifdef NPU_READY_WAIT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            we_q   <= xfer;
            if (xfer) begin
                wd_q <= s_data;
            end
            rv_q   <= oe_q;
            if (oe_q) begin
                rd_q <= npu_data;
            end
            done_q <= 1'b0;

            unique case (state_q)
                S_IDLE, S_FIN: begin
                    state_q <= S_IDLE;
                    if (s_valid) begin
                        state_q <= S_HDR;
                        sr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        nw_q    <= num_w;
                        calc_q  <= calc_cycles;
                        idx_q   <= '0;
`ifdef NPU_READY_WAIT_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == WCNT_W'(1)) begin
                            nin_q <= s_data[4:0];
                        end
                        if (idx_q == WCNT_W'(4)) begin
                            nout_q <= s_data[4:0];
                        end
                        if (idx_q == WCNT_W'(5)) begin
                            idx_q   <= '0;
                            state_q <= (nw_q == '0) ? S_INP : S_WGT;
                        end
                    end
                end
                S_WGT: begin
                    if (xfer) begin
                        if (idx_q == nw_q - WCNT_W'(1)) begin
                            idx_q   <= '0;
                            state_q <= S_INP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_INP: begin
                    if (xfer) begin
                        if (idx_q == WCNT_W'(nin_q)) begin
                            idx_q   <= '0;
                            sr_q    <= 1'b0;
                            cyc_q   <= calc_q;
                            state_q <= S_CALC;
`ifdef NPU_READY_WAIT_EN
                            tmo_q   <= '0;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (cyc_q != '0) begin
                        cyc_q <= cyc_q - 1'b1;
`ifdef NPU_READY_WAIT_EN
                    end else if (npu_ready) begin
                        state_q <= S_READ;
                        oe_q    <= 1'b1;
                        idx_q   <= '0;
                    end else if (tmo_q == '1) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`else
                    end else begin
                        state_q <= S_READ;
                        oe_q    <= 1'b1;
                        idx_q   <= '0;
                    end
`endif
                end
                S_READ: begin
                    // One extra cycle after the last oe lets the final result out
                    if (oe_q) begin
                        if (idx_q == WCNT_W'(nout_q)) begin
                            oe_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
